// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_ctrl.
// The master drives register-use demands; the slave returns stall/flush/forward controls.
interface hazard_ctrl_if;
    logic [4:0] RS_D;
    logic [4:0] RT_D;
    logic [1:0] TUSE_RS_D;
    logic [1:0] TUSE_RT_D;
    logic       MD_USE_D;
    logic [4:0] WRITE_ADDR_E;
    logic [4:0] WRITE_ADDR_M;
    logic [4:0] WRITE_ADDR_W;
    logic       REG_WRITE_ENABLED_E;
    logic       REG_WRITE_ENABLED_M;
    logic       REG_WRITE_ENABLED_W;
    logic [1:0] RES_E;
    logic [1:0] RES_M;
    logic       MD_START_E;
    logic       MD_OP_E;
    logic       EXC_REQ_M;

    logic       STALL_F;
    logic       STALL_D;
    logic       FLUSH_D;
    logic       FLUSH_E;
    logic       FLUSH_M;
    logic [1:0] FWD_RS_D;
    logic [1:0] FWD_RT_D;
    logic [1:0] FWD_RS_E;
    logic [1:0] FWD_RT_E;
    logic       MD_BUSY;

    modport master (
        output RS_D, RT_D, TUSE_RS_D, TUSE_RT_D, MD_USE_D,
        output WRITE_ADDR_E, WRITE_ADDR_M, WRITE_ADDR_W,
        output REG_WRITE_ENABLED_E, REG_WRITE_ENABLED_M, REG_WRITE_ENABLED_W,
        output RES_E, RES_M, MD_START_E, MD_OP_E, EXC_REQ_M,
        input  STALL_F, STALL_D, FLUSH_D, FLUSH_E, FLUSH_M,
        input  FWD_RS_D, FWD_RT_D, FWD_RS_E, FWD_RT_E, MD_BUSY
    );

    modport slave (
        input  RS_D, RT_D, TUSE_RS_D, TUSE_RT_D, MD_USE_D,
        input  WRITE_ADDR_E, WRITE_ADDR_M, WRITE_ADDR_W,
        input  REG_WRITE_ENABLED_E, REG_WRITE_ENABLED_M, REG_WRITE_ENABLED_W,
        input  RES_E, RES_M, MD_START_E, MD_OP_E, EXC_REQ_M,
        output STALL_F, STALL_D, FLUSH_D, FLUSH_E, FLUSH_M,
        output FWD_RS_D, FWD_RT_D, FWD_RS_E, FWD_RT_E, MD_BUSY
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Tuse/Tnew stall detection, D/E forwarding selects,
// multiply/divide busy counter and exception flush.
module hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] RES_NONE  = 2'b00;
    localparam logic [1:0] RES_ALU   = 2'b01;
    localparam logic [1:0] RES_MEM   = 2'b10;
    localparam logic [1:0] RES_PC8   = 2'b11;
    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_M     = 2'd1;
    localparam logic [1:0] FWD_W     = 2'd2;

    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic [REG_W-1:0] rs_e_q, rs_e_d;
    logic [REG_W-1:0] rt_e_q, rt_e_d;

    logic       valid_e, valid_m, m_fwd_ok, w_fwd_ok;
    logic [1:0] tnew_e, tnew_m;
    logic       md_busy, stall_data, stall_md, stall, exc, flush_e;

    // A source must wait when a pending producer delivers later than the source needs it.
    function automatic logic src_stall(
        input logic [REG_W-1:0] src,
        input logic [1:0]       tuse,
        input logic             ve,
        input logic [REG_W-1:0] ae,
        input logic [1:0]       te,
        input logic             vm,
        input logic [REG_W-1:0] am,
        input logic [1:0]       tm
    );
        src_stall = (src != '0) && (tuse != TUSE_NONE) &&
                    ((ve && (src == ae) && (te > tuse)) ||
                     (vm && (src == am) && (tm > tuse)));
    endfunction

    // M beats W; register 0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             m_ok,
        input logic [REG_W-1:0] am,
        input logic             w_ok,
        input logic [REG_W-1:0] aw
    );
        if (src == '0) begin
            fwd_sel = FWD_RF;
        end else if (m_ok && (src == am)) begin
            fwd_sel = FWD_M;
        end else if (w_ok && (src == aw)) begin
            fwd_sel = FWD_W;
        end else begin
            fwd_sel = FWD_RF;
        end
    endfunction

    // Producer classification and hazard/flush decisions.
    always_comb begin
        valid_e  = hz.REG_WRITE_ENABLED_E && (hz.WRITE_ADDR_E != '0) && (hz.RES_E != RES_NONE);
        valid_m  = hz.REG_WRITE_ENABLED_M && (hz.WRITE_ADDR_M != '0) && (hz.RES_M != RES_NONE);
        w_fwd_ok = hz.REG_WRITE_ENABLED_W && (hz.WRITE_ADDR_W != '0);

        tnew_e = 2'd0;
        unique case (hz.RES_E)
            RES_ALU, RES_PC8: tnew_e = 2'd1;
            RES_MEM:          tnew_e = 2'd2;
            default:          tnew_e = 2'd0;
        endcase
        tnew_m   = (hz.RES_M == RES_MEM) ? 2'd1 : 2'd0;
        m_fwd_ok = valid_m && (tnew_m == 2'd0);

        md_busy    = (md_cnt_q != '0);
        stall_data = src_stall(hz.RS_D, hz.TUSE_RS_D, valid_e, hz.WRITE_ADDR_E, tnew_e,
                               valid_m, hz.WRITE_ADDR_M, tnew_m) ||
                     src_stall(hz.RT_D, hz.TUSE_RT_D, valid_e, hz.WRITE_ADDR_E, tnew_e,
                               valid_m, hz.WRITE_ADDR_M, tnew_m);
        stall_md   = hz.MD_USE_D && (md_busy || hz.MD_START_E);
        stall      = stall_data || stall_md;
        exc        = hz.EXC_REQ_M;
        flush_e    = stall || exc;
    end

    // Outputs are gated to zero while reset is held.
    always_comb begin
        hz.STALL_F  = 1'b0;
        hz.STALL_D  = 1'b0;
        hz.FLUSH_D  = 1'b0;
        hz.FLUSH_E  = 1'b0;
        hz.FLUSH_M  = 1'b0;
        hz.FWD_RS_D = FWD_RF;
        hz.FWD_RT_D = FWD_RF;
        hz.FWD_RS_E = FWD_RF;
        hz.FWD_RT_E = FWD_RF;
        hz.MD_BUSY  = 1'b0;
        if (reset) begin
            hz.STALL_F  = stall && !exc;
            hz.STALL_D  = stall && !exc;
            hz.FLUSH_D  = exc;
            hz.FLUSH_E  = flush_e;
            hz.FLUSH_M  = exc;
            hz.FWD_RS_D = fwd_sel(hz.RS_D, m_fwd_ok, hz.WRITE_ADDR_M, w_fwd_ok, hz.WRITE_ADDR_W);
            hz.FWD_RT_D = fwd_sel(hz.RT_D, m_fwd_ok, hz.WRITE_ADDR_M, w_fwd_ok, hz.WRITE_ADDR_W);
            hz.FWD_RS_E = fwd_sel(rs_e_q, m_fwd_ok, hz.WRITE_ADDR_M, w_fwd_ok, hz.WRITE_ADDR_W);
            hz.FWD_RT_E = fwd_sel(rt_e_q, m_fwd_ok, hz.WRITE_ADDR_M, w_fwd_ok, hz.WRITE_ADDR_W);
            hz.MD_BUSY  = md_busy;
        end
    end

    // Busy counter ignores new starts while running; an exception blocks only a fresh load.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end else if (hz.MD_START_E && !hz.EXC_REQ_M) begin
            md_cnt_d = hz.MD_OP_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end

        rs_e_d = flush_e ? '0 : hz.RS_D;
        rt_e_d = flush_e ? '0 : hz.RT_D;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            md_cnt_q <= '0;
            rs_e_q   <= '0;
            rt_e_q   <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
            rs_e_q   <= rs_e_d;
            rt_e_q   <= rt_e_d;
        end
    end
endmodule
